// File: rtl/serial_alu_seq_if.sv
// Request/response bundle of the bit-serial ALU sequencer.
// The requester drives the operation inputs; the sequencer returns status, result and flags.
interface serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       opsel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             err;

    modport master (
        output start, opsel, a, b, cin,
        input  ready, done, result, cout, ovf, zero, err
    );

    modport slave (
        input  start, opsel, a, b, cin,
        output ready, done, result, cout, ovf, zero, err
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: one full-adder slice, one bit per clock, LSB first.
// The carry is fed back to the slice; result and flags update at the end of the run.
module serial_alu_seq #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input logic              clk,
    input logic              rst,
    serial_alu_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_bop;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_err;

    logic [WIDTH-1:0] w_bop;
    logic             w_c0;
    logic             w_legal;
    logic             w_accept;
    logic             w_reject;
    logic             w_last;
    logic             w_sum;
    logic             w_cnext;
    logic [WIDTH-1:0] w_sh_nxt;

    // Operand conditioning: b is pre-transformed once at acceptance
    always_comb begin
        w_bop   = bus.b;
        w_c0    = 1'b0;
        w_legal = 1'b1;
        case (bus.opsel)
            3'b000: begin w_bop = bus.b;           w_c0 = 1'b0;    end
            3'b001: begin w_bop = ~bus.b;          w_c0 = 1'b1;    end
            3'b011: begin w_bop = ~bus.b;          w_c0 = 1'b0;    end
            3'b100: begin w_bop = '0;              w_c0 = 1'b1;    end
            3'b101: begin w_bop = '1;              w_c0 = 1'b0;    end
            3'b110: begin w_bop = bus.b;           w_c0 = bus.cin; end
            default: begin w_bop = '0;             w_c0 = 1'b0; w_legal = 1'b0; end
        endcase
    end

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_sum    = r_a[0] ^ r_bop[0] ^ r_carry;
    assign w_cnext  = (r_a[0] & r_bop[0]) | (r_a[0] & r_carry) | (r_bop[0] & r_carry);
    assign w_sh_nxt = {w_sum, r_sh[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_legal) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else if (bus.start) begin
                    w_reject    = 1'b1;
                end
            end
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operand shifters carry no reset: they are always loaded before use
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a   <= bus.a;
            r_bop <= w_bop;
        end else if (r_state == S_RUN) begin
            r_a   <= r_a >> 1;
            r_bop <= r_bop >> 1;
            r_sh  <= w_sh_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_reject;
            if (w_accept) begin
                r_carry <= w_c0;
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_carry <= w_cnext;
                if (w_last) begin
                    // r_carry here is the carry into the MSB
                    r_cnt    <= '0;
                    r_result <= w_sh_nxt;
                    r_cout   <= w_cnext;
                    r_ovf    <= r_carry ^ w_cnext;
                    r_zero   <= (w_sh_nxt == '0);
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ready  = (r_state == S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;
    assign bus.zero   = r_zero;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized self-checking bench for serial_alu_seq against an arithmetic reference model.
module tb_serial_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_alu_seq_if #(.WIDTH(W)) bus ();
    serial_alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] e_res;
    logic         e_co, e_ov, e_z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the conditioned b operand
    task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output logic [W-1:0] r, output logic co,
                         output logic ov, output logic z);
        logic [W-1:0] bop;
        logic         c0;
        logic [W:0]   s;
        case (op)
            3'd0: begin bop = b;  c0 = 1'b0; end
            3'd1: begin bop = ~b; c0 = 1'b1; end
            3'd3: begin bop = ~b; c0 = 1'b0; end
            3'd4: begin bop = '0; c0 = 1'b1; end
            3'd5: begin bop = '1; c0 = 1'b0; end
            default: begin bop = b; c0 = cin; end
        endcase
        s  = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, c0};
        r  = s[W-1:0];
        co = s[W];
        ov = (a[W-1] == bop[W-1]) && (r[W-1] != a[W-1]);
        z  = (r == '0);
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_res"},  bus.result, e_res);
        chk({tag, "_cout"}, bus.cout,   e_co);
        chk({tag, "_ovf"},  bus.ovf,    e_ov);
        chk({tag, "_zero"}, bus.zero,   e_z);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic cin, input bit disturb);
        int lat;
        int extra;
        bit seen;
        logic [W-1:0] r;
        logic co, ov, z;
        model(op, a, b, cin, r, co, ov, z);
        @(negedge clk);
        lat = 0;
        while (!bus.ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_ready"}, bus.ready, 1'b1);
        bus.start = 1'b1; bus.opsel = op; bus.a = a; bus.b = b; bus.cin = cin;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom); bus.opsel = 3'($urandom);
        lat = 0;
        seen = 0;
        while (lat < 40 && !seen) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1;
            else begin
                if (lat == 2) chk({tag, "_busy"}, bus.ready, 1'b0);
                bus.start = disturb && (lat == 3);
                if (bus.start) begin bus.a = W'($urandom); bus.b = W'($urandom); end
            end
        end
        bus.start = 1'b0;
        chk({tag, "_lat"}, lat, W + 1);
        e_res = r; e_co = co; e_ov = ov; e_z = z;
        check_outs(tag);
        @(negedge clk);
        chk({tag, "_pulse"}, {bus.done, bus.ready}, 2'b01);
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < W + 3; i++) begin
                @(negedge clk);
                if (bus.done) extra++;
            end
            chk({tag, "_nodup"}, extra, 0);
            check_outs({tag, "_hold"});
        end
    endtask

    task automatic illegal(input string tag, input logic [2:0] op);
        @(negedge clk);
        bus.start = 1'b1; bus.opsel = op; bus.a = W'($urandom); bus.b = W'($urandom);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk({tag, "_err"}, {bus.err, bus.done, bus.ready}, 3'b101);
        check_outs(tag);
        @(negedge clk);
        chk({tag, "_err_off"}, {bus.err, bus.done}, 2'b00);
    endtask

    initial begin
        logic [2:0] legal_ops [6];
        int dcount;
        legal_ops = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6};
        bus.start = 1'b0; bus.opsel = '0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        e_res = '0; e_co = 1'b0; e_ov = 1'b0; e_z = 1'b0;
        chk("rst_ctl", {bus.ready, bus.done, bus.err}, 3'b100);
        check_outs("rst");

        run_op("add_ovf", 3'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
        run_op("sub_eq",  3'd1, 8'h05, 8'h05, 1'b0, 1'b0);
        run_op("sub_neg", 3'd1, 8'h00, 8'h01, 1'b0, 1'b0);
        run_op("inc_wrap", 3'd4, 8'hFF, 8'h5A, 1'b0, 1'b0);
        run_op("dec_wrap", 3'd5, 8'h00, 8'hA5, 1'b0, 1'b0);
        run_op("adc",     3'd6, 8'h10, 8'h20, 1'b1, 1'b0);
        run_op("anb",     3'd3, 8'h09, 8'h03, 1'b0, 1'b0);
        illegal("ill111", 3'b111);
        illegal("ill010", 3'b010);
        run_op("disturb", 3'd0, 8'h01, 8'h01, 1'b0, 1'b1);

        // Abort mid-run with reset
        @(negedge clk);
        bus.start = 1'b1; bus.opsel = 3'd0; bus.a = 8'h33; bus.b = 8'h44;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        e_res = '0; e_co = 1'b0; e_ov = 1'b0; e_z = 1'b0;
        chk("abort_ctl", {bus.ready, bus.done, bus.err}, 3'b100);
        check_outs("abort");
        dcount = 0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        chk("abort_nodone", dcount, 0);
        run_op("after_abort", 3'd1, 8'h80, 8'h01, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0)
                illegal("rnd_ill", ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b111);
            else
                run_op("rnd", legal_ops[$urandom_range(0, 5)], W'($urandom), W'($urandom),
                       1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
